gate_eval_arbiter: RTL and testbench

//  Shares one N-input logic-gate evaluation unit between NREQ requesters.

---
 rtl/gate_eval_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_gate_eval_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter sharing one masked N-input gate evaluator among NREQ requesters.
// Optional response counter stat_ops is enabled by defining GATE_EVAL_ARB_STATS_EN.
module gate_eval_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*3-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*WIDTH-1:0]   req_mask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_y,
`ifdef GATE_EVAL_ARB_STATS_EN
  output logic [15:0]             stat_ops,
`endif
  output logic                    busy
);

  if (NREQ < 2 || NREQ > 16 || WIDTH < 1 || WIDTH > 32) begin : g_bad_param
    $error("gate_eval_arbiter: NREQ must be 2..16 and WIDTH 1..32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_mask;
  logic [IDW-1:0]     r_id;
  logic               r_rsp_valid;
  logic               r_rsp_y;
  logic               r_busy;

  logic               w_found;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_next_ptr;
  logic [NREQ-1:0]    w_ready;
  logic               w_rsp_hs;

  // Masked identities fall out naturally: unmasked bits are forced to the neutral value.
  function automatic logic f_gate_eval(input logic [2:0] op,
                                       input logic [WIDTH-1:0] data,
                                       input logic [WIDTH-1:0] mask);
    logic l_and;
    logic l_or;
    logic l_xor;
    logic l_low;
    logic l_seen;
    logic l_y;
    l_and  = &(data | ~mask);
    l_or   = |(data & mask);
    l_xor  = ^(data & mask);
    l_low  = 1'b0;
    l_seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!l_seen && mask[i]) begin
        l_low  = data[i];
        l_seen = 1'b1;
      end
    end
    case (op)
      3'd0:    l_y = l_and;
      3'd1:    l_y = l_or;
      3'd2:    l_y = l_xor;
      3'd3:    l_y = ~l_xor;
      3'd4:    l_y = ~l_and;
      3'd5:    l_y = ~l_or;
      3'd6:    l_y = l_low;
      3'd7:    l_y = ~l_low;
      default: l_y = 1'b0;
    endcase
    return l_y;
  endfunction

  // Round-robin search for the first valid requester starting at r_rr_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!w_found && req_valid[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'(idx);
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
  end

  // Winner-only ready, suppressed outside IDLE and while reset is held.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      w_ready[w_gnt_idx] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Pointer advance with wrap from NREQ-1 to 0.
  always_comb begin
    w_next_ptr = '0;
    if (w_gnt_idx == IDW'(NREQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_gnt_idx + IDW'(1);
    end
  end

  assign w_rsp_hs = r_rsp_valid && rsp_ready;

  // Control FSM: grant and latch in IDLE, evaluate in EVAL, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_op        <= 3'd0;
      r_data      <= '0;
      r_mask      <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op     <= req_op[w_gnt_idx*3 +: 3];
            r_data   <= req_data[w_gnt_idx*WIDTH +: WIDTH];
            r_mask   <= req_mask[w_gnt_idx*WIDTH +: WIDTH];
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b1;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_rsp_y     <= f_gate_eval(r_op, r_data, r_mask);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_EVAL_ARB_STATS_EN
  logic [15:0] r_stat_ops;

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops <= 16'd0;
    end else if (w_rsp_hs && (r_stat_ops != 16'hFFFF)) begin
      r_stat_ops <= r_stat_ops + 16'd1;
    end
  end

  assign stat_ops = r_stat_ops;
`endif

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_y     = r_rsp_y;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Self-checking bench for gate_eval_arbiter: directed spec scenarios plus random traffic
// compared against a bit-counting reference model of the gates and round-robin order.
module tb_gate_eval_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*3-1:0]    req_op;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ*W-1:0]    req_mask;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_y;
  logic                 busy;
`ifdef GATE_EVAL_ARB_STATS_EN
  logic [15:0]          stat_ops;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  int m_done   = 0;
  int cyc      = 0;
  int last_gnt = -1;
  int gap_chk  = 0;

  gate_eval_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y),
`ifdef GATE_EVAL_ARB_STATS_EN
    .stat_ops(stat_ops),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference gate: counts selected bits rather than using reduction operators.
  function automatic logic model_eval(input int op, input logic [W-1:0] d, input logic [W-1:0] m);
    int n, ones, first;
    n = 0; ones = 0; first = -1;
    for (int i = 0; i < W; i++) begin
      if (m[i]) begin
        n++;
        if (d[i]) ones++;
        if (first < 0) first = i;
      end
    end
    case (op)
      0: return ones == n;
      1: return ones > 0;
      2: return (ones % 2) == 1;
      3: return (ones % 2) == 0;
      4: return ones != n;
      5: return ones == 0;
      6: return (first < 0) ? 1'b0 : d[first];
      default: return (first < 0) ? 1'b1 : !d[first];
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input int op, input logic [W-1:0] d,
                         input logic [W-1:0] m);
    req_valid[i]      = v;
    req_op[i*3 +: 3]  = 3'(op);
    req_data[i*W +: W] = d;
    req_mask[i*W +: W] = m;
  endtask

  // One full transaction from an IDLE cycle; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(input int hold, input string tag);
    int g;
    logic ey;
    logic [NREQ-1:0] onehot;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    @(negedge clk);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    if (g < 0) begin
      check({tag, ".no_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      return;
    end
    onehot = '0;
    onehot[g] = 1'b1;
    check({tag, ".ready"}, 32'(req_ready), 32'(onehot));
    ey = model_eval(int'(req_op[g*3 +: 3]), req_data[g*W +: W], req_mask[g*W +: W]);
    @(posedge clk);
    if (gap_chk != 0 && last_gnt >= 0) check({tag, ".gap"}, 32'(cyc - last_gnt), 32'd3);
    last_gnt = cyc;
    m_ptr = (g + 1) % NREQ;
    #1;
    req_data  = {$urandom, $urandom};
    rsp_ready = (hold == 0);
    @(negedge clk);
    check({tag, ".eval_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".eval_busy"}, 32'(busy), 32'd1);
    check({tag, ".eval_valid"}, 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_id"}, 32'(rsp_id), 32'(g));
    check({tag, ".rsp_y"}, 32'(rsp_y), 32'(ey));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (h == hold - 1) rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_id"}, 32'(rsp_id), 32'(g));
      check({tag, ".hold_y"}, 32'(rsp_y), 32'(ey));
    end
    @(posedge clk); #1;
    m_done++;
`ifdef GATE_EVAL_ARB_STATS_EN
    check({tag, ".stat_ops"}, 32'(stat_ops), 32'(m_done));
`endif
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_op = '0; req_data = '0; req_mask = '0;
    set_req(2, 1'b1, 0, 8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.id", 32'(rsp_id), 32'd0);
    check("rst.y", 32'(rsp_y), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
`ifdef GATE_EVAL_ARB_STATS_EN
    check("rst.stat", 32'(stat_ops), 32'd0);
`endif
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_req(0, 1'b1, 0, 8'hFF, 8'h0F);
    txn(0, "t1_and");
    req_valid = '0;
    set_req(1, 1'b1, 2, 8'b0000_0111, 8'hFF);
    txn(0, "t2_xor");
    set_req(1, 1'b1, 3, 8'b0000_0111, 8'hFF);
    txn(0, "t2_xnor");
    req_valid = '0;

    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 8'hA5, 8'h3C);
    gap_chk = 1; last_gnt = -1;
    for (int n = 0; n < 5; n++) begin
      if (n == 0) check("t3.start_ptr", 32'(m_ptr), 32'd2);
      txn(0, "t3_rr");
    end
    gap_chk = 0;
    req_valid = '0;

    set_req(m_ptr, 1'b1, 4, 8'hFF, 8'h00);
    txn(0, "t4_nand");
    set_req(m_ptr, 1'b1, 5, 8'h00, 8'h00);
    txn(0, "t4_nor");
    set_req(m_ptr, 1'b1, 7, 8'h00, 8'h00);
    txn(0, "t4_not");
    req_valid = '0;

    set_req(2, 1'b1, 6, 8'b0000_0100, 8'b0010_0100);
    txn(5, "t5_buf");
    req_valid = '0;

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      txn(int'($urandom_range(0, 2)), "rand");
    end
    req_valid = '0;

    set_req(3, 1'b1, 1, 8'hFF, 8'hFF);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6.valid", 32'(rsp_valid), 32'd0);
    check("t6.busy", 32'(busy), 32'd0);
    check("t6.ready", 32'(req_ready), 32'd0);
`ifdef GATE_EVAL_ARB_STATS_EN
    check("t6.stat", 32'(stat_ops), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; m_ptr = 0; m_done = 0;
    set_req(0, 1'b1, 0, 8'h01, 8'h01);
    txn(0, "t6_after");
    req_valid = '0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
